// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (i_*) and
// load/store (d_*) requesters. One outstanding transaction; data has
// priority; a streak counter forces a fetch grant after STARVE_LIMIT data
// grants made while fetch was waiting. Responses are routed to the owner.
// Ports: clk, reset (sync, active-high); i_req/i_addr -> i_gnt/i_rvalid/
// i_rdata; d_req/d_addr/d_we/d_wstrb/d_wdata -> d_gnt/d_rvalid/d_rdata;
// mem_req/mem_addr/mem_we/mem_wstrb/mem_wdata, mem_ready/mem_rvalid/mem_rdata.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic          own_d;
    logic [SW-1:0] streak;
    logic [31:0]   lat_addr;
    logic          lat_we;
    logic [3:0]    lat_wstrb;
    logic [31:0]   lat_wdata;

    logic          win_d;
    logic          win_i;
    logic          sel_d;
    logic          active;
    logic          accept;
    logic          resp;
    logic [31:0]   f_addr;
    logic          f_we;
    logic [3:0]    f_wstrb;
    logic [31:0]   f_wdata;

    // Data wins unless fetch is waiting and has been passed over too often.
    assign win_d = d_req && !(i_req && (streak == LIMIT));
    assign win_i = !win_d && i_req;

    assign sel_d  = (state == IDLE) ? win_d : own_d;
    assign active = ((state == IDLE) && (win_d || win_i)) || (state == REQ);
    assign accept = active && mem_ready;
    assign resp   = (state == RESP) && mem_rvalid;

    // Winner's fields; fetch presents a read with no write data.
    always_comb begin
        f_addr  = 32'h0;
        f_we    = 1'b0;
        f_wstrb = 4'h0;
        f_wdata = 32'h0;
        unique case (1'b1)
            win_d: begin
                f_addr  = d_addr;
                f_we    = d_we;
                f_wstrb = d_wstrb;
                f_wdata = d_wdata;
            end
            win_i: begin
                f_addr  = i_addr;
            end
            default: ;
        endcase
    end

    // Everything is forced to zero while reset is held.
    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = 32'h0;
        mem_we    = 1'b0;
        mem_wstrb = 4'h0;
        mem_wdata = 32'h0;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        i_rdata   = 32'h0;
        d_rdata   = 32'h0;
        if (!reset) begin
            mem_req = active;
            if (state == REQ) begin
                mem_addr  = lat_addr;
                mem_we    = lat_we;
                mem_wstrb = lat_wstrb;
                mem_wdata = lat_wdata;
            end else if (state == IDLE) begin
                mem_addr  = f_addr;
                mem_we    = f_we;
                mem_wstrb = f_wstrb;
                mem_wdata = f_wdata;
            end
            i_gnt    = accept && !sel_d;
            d_gnt    = accept && sel_d;
            i_rvalid = resp && !own_d;
            d_rvalid = resp && own_d;
            if (resp && !own_d) begin
                i_rdata = mem_rdata;
            end
            if (resp && own_d && !lat_we) begin
                d_rdata = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            own_d     <= 1'b0;
            streak    <= '0;
            lat_addr  <= 32'h0;
            lat_we    <= 1'b0;
            lat_wstrb <= 4'h0;
            lat_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_d || win_i) begin
                        own_d     <= win_d;
                        lat_addr  <= f_addr;
                        lat_we    <= f_we;
                        lat_wstrb <= f_wstrb;
                        lat_wdata <= f_wdata;
                        state     <= mem_ready ? RESP : REQ;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Count data grants made while fetch was left waiting.
            if (accept) begin
                if (!sel_d) begin
                    streak <= '0;
                end else if (i_req) begin
                    if (streak != LIMIT) begin
                        streak <= streak + SW'(1);
                    end
                end else begin
                    streak <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a simple memory
// responder; response data is predicted at grant time and checked on rvalid.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic [3:0]  d_wstrb;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] iq[$];
    logic [31:0] dq[$];
    bit          glog[$];

    logic        hold_resp = 1'b0;
    logic        inject = 1'b0;
    logic        m_acc;
    logic        m_inj;
    logic        m_we;
    logic [31:0] m_addr;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk),
        .reset(reset),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_gnt(i_gnt),
        .i_rvalid(i_rvalid),
        .i_rdata(i_rdata),
        .d_req(d_req),
        .d_addr(d_addr),
        .d_we(d_we),
        .d_wstrb(d_wstrb),
        .d_wdata(d_wdata),
        .d_gnt(d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h40) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_zero;
        check("rst_ctl", {i_gnt, i_rvalid, d_gnt, d_rvalid,
                          mem_req, mem_we, mem_wstrb}, 64'h0);
        check("rst_rdata", {i_rdata, d_rdata}, 64'h0);
        check("rst_maddr", mem_addr, 64'h0);
        check("rst_wdata", mem_wdata, 64'h0);
    endtask

    // Memory responder: answers one cycle after acceptance.
    always @(posedge clk) begin
        m_acc  = mem_req && mem_ready && !reset && !hold_resp;
        m_inj  = inject;
        m_we   = mem_we;
        m_addr = mem_addr;
        #1;
        mem_rvalid = m_acc || m_inj;
        mem_rdata  = m_inj ? 32'hBAD0_BAD0 :
                     (m_we ? 32'hFFFF_FFFF : rd_fn(m_addr));
    end

    // Scoreboard: predict at grant, compare at rvalid.
    always @(negedge clk) begin
        if (!reset) begin
            if (i_gnt) begin
                glog.push_back(1'b0);
                iq.push_back(rd_fn(i_addr));
            end
            if (d_gnt) begin
                glog.push_back(1'b1);
                dq.push_back(d_we ? 32'h0 : rd_fn(d_addr));
            end
            if (i_rvalid) begin
                if (iq.size() == 0) check("i_rvalid_unexp", 1, 0);
                else check("i_rdata", i_rdata, iq.pop_front());
            end
            if (d_rvalid) begin
                if (dq.size() == 0) check("d_rvalid_unexp", 1, 0);
                else check("d_rdata", d_rdata, dq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        reset = 1'b1;
        i_req = 1'b0;
        i_addr = 32'h0;
        d_req = 1'b0;
        d_addr = 32'h0;
        d_we = 1'b0;
        d_wstrb = 4'h0;
        d_wdata = 32'h0;
        mem_ready = 1'b1;

        // Reset with both requesters active: all outputs zero.
        cyc;
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_addr = 32'h80;
        neg;
        chk_zero;
        cyc;
        i_req = 1'b0; d_req = 1'b0;
        reset = 1'b0;

        // Fetch only, zero-wait memory.
        cyc;
        i_req = 1'b1; i_addr = 32'h40;
        neg;
        check("f_gnt_c0", i_gnt, 1);
        check("f_mreq_c0", mem_req, 1);
        check("f_maddr_c0", mem_addr, 32'h40);
        cyc;
        neg;
        check("f_rvalid_c1", i_rvalid, 1);
        check("f_rdata_c1", i_rdata, 32'h13);
        check("f_mreq_c1", mem_req, 0);
        cyc;
        neg;
        check("f_mreq_c2", mem_req, 1);
        cyc;
        i_req = 1'b0;
        cyc;

        // Starvation: both held, expect D D D D I D D D D I.
        i_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        base = glog.size();
        for (int t = 0; t < 200; t++) begin
            neg;
            if (glog.size() >= base + 10) break;
        end
        cyc;
        i_req = 1'b0; d_req = 1'b0;
        check("starve_count", (glog.size() >= base + 10), 1);
        for (int k = 0; k < 10; k++) begin
            if (base + k < glog.size())
                check("starve_order", glog[base + k], (k % 5 != 4));
        end
        cyc; cyc; cyc;

        // Memory stalls with fetch owning; data arrives meanwhile.
        mem_ready = 1'b0;
        i_req = 1'b1; i_addr = 32'h200;
        for (int k = 0; k < 3; k++) begin
            neg;
            check("stall_mreq", mem_req, 1);
            check("stall_maddr", mem_addr, 32'h200);
            check("stall_ignt", i_gnt, 0);
            cyc;
            if (k == 0) begin
                d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0;
            end
        end
        mem_ready = 1'b1;
        neg;
        check("stall_ignt_rdy", i_gnt, 1);
        check("stall_dgnt_rdy", d_gnt, 0);
        check("stall_maddr_rdy", mem_addr, 32'h200);
        cyc;
        i_req = 1'b0;
        for (int t = 0; t < 10; t++) begin
            neg;
            if (d_gnt) break;
        end
        check("stall_dgnt_next", d_gnt, 1);
        check("stall_daddr", mem_addr, 32'h300);
        cyc;
        d_req = 1'b0;
        cyc; cyc;

        // Store: write fields reach memory, ack carries zero data.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100;
        d_wstrb = 4'h3; d_wdata = 32'hDEADBEEF;
        neg;
        check("st_gnt", d_gnt, 1);
        check("st_we", mem_we, 1);
        check("st_wstrb", mem_wstrb, 4'h3);
        check("st_wdata", mem_wdata, 32'hDEADBEEF);
        check("st_addr", mem_addr, 32'h100);
        cyc;
        d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0; d_wdata = 32'h0;
        neg;
        check("st_ack", d_rvalid, 1);
        check("st_rdata0", d_rdata, 0);
        cyc;

        // Spurious mem_rvalid while idle.
        inject = 1'b1;
        cyc;
        inject = 1'b0;
        neg;
        check("spur_irv", i_rvalid, 0);
        check("spur_drv", d_rvalid, 0);
        check("spur_mreq", mem_req, 0);
        cyc;
        i_req = 1'b1; i_addr = 32'h44;
        neg;
        check("spur_after_gnt", i_gnt, 1);
        cyc;
        i_req = 1'b0;
        cyc;

        // Reset during RESP, then a late response.
        hold_resp = 1'b1;
        i_req = 1'b1; i_addr = 32'h48;
        neg;
        check("rr_gnt", i_gnt, 1);
        cyc;
        reset = 1'b1;
        d_req = 1'b1; d_addr = 32'h80;
        neg;
        chk_zero;
        cyc;
        reset = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        iq.delete();
        hold_resp = 1'b0;
        inject = 1'b1;
        cyc;
        inject = 1'b0;
        neg;
        check("rr_late_irv", i_rvalid, 0);
        check("rr_late_drv", d_rvalid, 0);
        cyc;
        d_req = 1'b1; d_addr = 32'h84;
        neg;
        check("rr_next_gnt", d_gnt, 1);
        check("rr_next_addr", mem_addr, 32'h84);
        cyc;
        d_req = 1'b0;
        neg;
        check("rr_next_rv", d_rvalid, 1);
        check("rr_next_data", d_rdata, rd_fn(32'h84));
        cyc; cyc;

        check("iq_drained", iq.size(), 0);
        check("dq_drained", dq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter that shares one unified memory port between the core's instruction-fetch requester and its load/store requester. It sits between the RV32I core and a single-port RAM/ROM model. It issues at most one outstanding transaction at a time. Data accesses have priority, and a starvation counter guarantees that fetch makes forward progress. Each response is routed back to the requester that issued it.

## Interface
- STARVE_LIMIT, 4: after this many consecutive data grants made while fetch was waiting, the next arbitration goes to fetch; must be ≥1
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request
- i_addr  in  32  fetch byte address
- i_gnt  out  1  fetch request accepted by memory (1-cycle pulse)
- i_rvalid  out  1  fetch response valid (1-cycle pulse)
- i_rdata  out  32  fetch response data
- d_req  in  1  data request
- d_addr  in  32  data byte address
- d_we  in  1  1 = store, 0 = load
- d_wstrb  in  4  store byte enables
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted (1-cycle pulse)
- d_rvalid  out  1  data response valid; stores also get one (as an ack)
- d_rdata  out  32  load data; 0 for stores
- mem_req  out  1  request to memory
- mem_addr  out  32  memory address
- mem_we  out  1  memory write enable
- mem_wstrb  out  4  memory byte enables
- mem_wdata  out  32  memory write data
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  32  memory read data

## Operation
- States: IDLE, REQ (request presented but not yet accepted; owner locked), RESP (accepted; waiting for mem_rvalid). Owner register: I or D.
- Arbitration in IDLE, combinational:
  - winner = D if d_req and not (i_req and streak == STARVE_LIMIT);
  - otherwise winner = I if i_req;
  - otherwise none.
- mem_req is 1 in IDLE when there is a winner, and 1 in REQ. It is 0 in RESP.
- mem_* fields are muxed from the winner in IDLE and from the locked owner in REQ. Fetch drives mem_we = 0, mem_wstrb = 0 and mem_wdata = 0.
- Acceptance happens when mem_req && mem_ready.
  - Pulse x_gnt for the owner in that same cycle.
  - Move to RESP with the owner registered.
- mem_req && !mem_ready in IDLE: latch the winner as owner and move to REQ. The owner and mem fields stay stable until acceptance, even if the other requester asserts or the owner's req drops.
- RESP: when mem_rvalid = 1, assert x_rvalid = 1 for the owner and pass x_rdata = mem_rdata through (d_rdata = 0 for a store). Move to IDLE.
- mem_rvalid in IDLE or REQ is ignored.
- Streak counter, width $clog2(STARVE_LIMIT+1), updated on each acceptance:
  - I granted → 0;
  - D granted while i_req = 1 → saturating +1;
  - D granted while i_req = 0 → 0.
- Requesters must hold their req and fields stable until the gnt pulse. They may present a new request in the cycle after their rvalid.

## Timing
- Reset (synchronous): state = IDLE, streak = 0.
  - All outputs 0: gnt, rvalid, rdata and all mem_* outputs.
  - Reset asserted mid-transaction abandons it; a late mem_rvalid arriving in IDLE is dropped.
- Gnt has 0 cycles of latency from req when in IDLE and mem_ready = 1.
- rvalid is combinational from mem_rvalid, in the same cycle.
- Earliest next mem_req is the cycle after the rvalid cycle.
  - Best-case throughput is one transaction per 2 cycles, with a zero-wait memory that returns mem_rvalid in the cycle after acceptance.
- Simultaneous i_req and d_req with streak < STARVE_LIMIT: D wins and I waits; no i_gnt.
- No combinational path from mem_ready to mem_req.

## Test plan
- Fetch only, mem_ready = 1, mem_rvalid one cycle later with 0x00000013:
  - i_gnt in cycle 0;
  - i_rvalid with i_rdata = 0x00000013 in cycle 1;
  - mem_req = 0 in cycle 1;
  - next mem_req in cycle 2.
- Both requesting, STARVE_LIMIT = 4, d_req held continuously:
  - grant order D, D, D, D, I, D, D, D, D, I;
  - streak returns to 0 after each I grant.
- mem_ready held 0 for 3 cycles with owner I, then d_req rises:
  - mem_addr stays at i_addr;
  - i_gnt is given when ready rises;
  - d is served next.
- Store to 0x100 with d_wstrb = 0x3 and d_wdata = 0xDEADBEEF:
  - mem_we = 1 and mem_wstrb = 0x3 on the memory side;
  - d_rvalid pulses with d_rdata = 0 when the ack arrives.
- Reset asserted in RESP, then mem_rvalid arrives:
  - no x_rvalid;
  - all outputs 0 during reset;
  - the next request is arbitrated normally.
- Spurious mem_rvalid in IDLE: no rvalid on either requester; state unchanged.
